// File: rtl/systolic_feeder.sv
// systolic_feeder: holds two 4x4 byte matrices and streams them, skewed, into a
// 4x4 output-stationary systolic array (A rows from the west, B columns from the north).
module systolic_feeder #(
  parameter int unsigned DRAIN_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  output logic [7:0] inp_west0,
  output logic [7:0] inp_west4,
  output logic [7:0] inp_west8,
  output logic [7:0] inp_west12,
  output logic [7:0] inp_north0,
  output logic [7:0] inp_north1,
  output logic [7:0] inp_north2,
  output logic [7:0] inp_north3,
  output logic       arr_rst,
  output logic       busy,
  output logic       feed_done
);

  localparam int unsigned DW        = 8;
  localparam int unsigned N         = 4;
  localparam int unsigned SW        = 3;
  localparam int unsigned CW        = 8;
  localparam int unsigned FEED_LAST = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  logic [DW-1:0] mat_a [N][N];
  logic [DW-1:0] mat_b [N][N];

  state_t        state, state_nxt;
  logic [SW-1:0] step, step_nxt;
  logic [CW-1:0] drain, drain_nxt;

  logic [DW-1:0] west_nxt  [N];
  logic [DW-1:0] north_nxt [N];
  logic [DW-1:0] west_q    [N];
  logic [DW-1:0] north_q   [N];
  logic          arr_rst_nxt, busy_nxt, done_nxt;

  // Matrix storage: writable only while idle, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mat_a[r][c] <= '0;
          mat_b[r][c] <= '0;
        end
      end
    end else if (state == IDLE && wr_en) begin
      if (wr_sel) mat_b[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
      else        mat_a[wr_addr[3:2]][wr_addr[1:0]] <= wr_data;
    end
  end

  // State register with its step and drain counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      drain <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      drain <= drain_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    drain_nxt = drain;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = FEED;
        step_nxt  = '0;
      end
      FEED: begin
        if (step == SW'(FEED_LAST)) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end else begin
          step_nxt = step + SW'(1);
        end
      end
      DRAIN: begin
        if (drain == CW'(DRAIN_CYCLES - 1)) state_nxt = DONE;
        else                                drain_nxt = drain + CW'(1);
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so they can be registered.
  always_comb begin
    arr_rst_nxt = (state_nxt == CLEAR);
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == DONE);
    for (int i = 0; i < N; i++) begin
      west_nxt[i]  = '0;
      north_nxt[i] = '0;
    end
    if (state_nxt == FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(step_nxt) == i + k) begin
            west_nxt[i]  = mat_a[i][k];
            north_nxt[i] = mat_b[k][i];
          end
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_rst   <= 1'b0;
      busy      <= 1'b0;
      feed_done <= 1'b0;
      for (int i = 0; i < N; i++) begin
        west_q[i]  <= '0;
        north_q[i] <= '0;
      end
    end else begin
      arr_rst   <= arr_rst_nxt;
      busy      <= busy_nxt;
      feed_done <= done_nxt;
      for (int i = 0; i < N; i++) begin
        west_q[i]  <= west_nxt[i];
        north_q[i] <= north_nxt[i];
      end
    end
  end

  assign inp_west0  = west_q[0];
  assign inp_west4  = west_q[1];
  assign inp_west8  = west_q[2];
  assign inp_west12 = west_q[3];
  assign inp_north0 = north_q[0];
  assign inp_north1 = north_q[1];
  assign inp_north2 = north_q[2];
  assign inp_north3 = north_q[3];

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter: DRAIN_CYCLES, 10, number of idle cycles after the last feed cycle before feed_done; legal range 1..255.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: wr_en  input  1  matrix element write strobe.
REQ-005 Port: wr_sel  input  1  target matrix: 0 = A (west operand), 1 = B (north operand).
REQ-006 Port: wr_addr  input  4  element index, row*4+col.
REQ-007 Port: wr_data  input  8  element value, unsigned.
REQ-008 Port: start  input  1  single-cycle request to stream the stored matrices.
REQ-009 Port: inp_west0, inp_west4, inp_west8, inp_west12  output  8 each  skewed A-row streams for array rows 0..3.
REQ-010 Port: inp_north0, inp_north1, inp_north2, inp_north3  output  8 each  skewed B-column streams for array columns 0..3.
REQ-011 Port: arr_rst  output  1  one-cycle clear pulse for the downstream systolic array.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: feed_done  output  1  one-cycle pulse at the end of DRAIN.

Function
REQ-014 Storage: two 4x4 arrays of 8-bit registers, A and B.
REQ-015 Write: in IDLE with wr_en=1, element wr_addr of the wr_sel matrix SHALL take wr_data at the clock edge; wr_en outside IDLE SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-017 IDLE -> CLEAR when start=1 at an edge; start in any other state SHALL be ignored.
REQ-018 A write and start in the same IDLE cycle SHALL both take effect; the written value SHALL appear in the stream.
REQ-019 CLEAR lasts 1 cycle with arr_rst=1, all streams 0; then FEED.
REQ-020 FEED lasts exactly 7 cycles, feed step t = 0..6, tracked by a 3-bit counter; then DRAIN.
REQ-021 During FEED step t: inp_west(4r) SHALL equal A[r][t-r] when 0 <= t-r <= 3, else 0, for r = 0..3.
REQ-022 During FEED step t: inp_north(c) SHALL equal B[t-c][c] when 0 <= t-c <= 3, else 0, for c = 0..3.
REQ-023 All stream outputs, arr_rst, busy and feed_done SHALL be registered (driven from flops, no combinational path from inputs).
REQ-024 DRAIN lasts DRAIN_CYCLES cycles with all streams 0; then DONE.
REQ-025 DONE lasts 1 cycle with feed_done=1, then IDLE; a start in the DONE cycle SHALL be ignored.
REQ-026 Stored matrices SHALL persist across runs; a second start without writes SHALL replay identical streams.
REQ-027 Total latency: start sampled at edge k -> arr_rst high in cycle k+1, FEED steps in cycles k+2..k+8, feed_done high in cycle k+9+DRAIN_CYCLES.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, clear A, B and all counters to 0, and drive all streams, arr_rst, busy and feed_done to 0 in the following cycle.
REQ-029 rst SHALL take priority over start and wr_en in the same cycle.
REQ-030 rst mid-FEED or mid-DRAIN SHALL abort the run with no feed_done pulse.

Verification
REQ-031 Load A and B row-major with 1..16, start -> step 0: west0=1, north0=1, others 0; step 1: west0=2, west4=5, north0=5, north1=2; step 3: west=4,7,10,13, north=13,10,7,4; step 6: west12=16, north3=16, others 0.
REQ-032 Same load, start at edge k with DRAIN_CYCLES=10 -> arr_rst high only in cycle k+1, busy high over cycles k+1..k+19, feed_done high only in cycle k+19.
REQ-033 Write A[2][1]=0xFF with wr_en and start in the same IDLE cycle -> west8=0xFF at FEED step 3.
REQ-034 wr_en with data 0xAA to A[0][0] during FEED, and start during DRAIN -> no stored value changes and no second run; a replay run shows west0=1 at step 0.
REQ-035 Assert rst at FEED step 2 -> next cycle all outputs 0, busy=0, no feed_done; a subsequent start streams all zeros.
REQ-036 Connect to the 4x4 systolic array with the REQ-031 load and wait for the array's done -> out00..out15 equal the product A*B, e.g. out00=90, out15=600.
